// File: rtl/alu_op_pkg.sv
// Shared definitions for the ALUop encoder: byte field positions, operation and
// opcode/funct codes, FSM state type and a helper that packs the ALUop byte.
package alu_op_pkg;

   localparam int unsigned OPC_W_DEF = 6;
   localparam int unsigned FN_W_DEF  = 5;

   localparam int unsigned BIT_ARITH = 7;
   localparam int unsigned BIT_TWOC  = 6;
   localparam int unsigned BIT_LR    = 5;
   localparam int unsigned OPER_HI   = 4;
   localparam int unsigned OPER_LO   = 3;
   localparam int unsigned FLAG_HI   = 2;
   localparam int unsigned FLAG_LO   = 0;

   localparam logic [2:0] FLAG_ALL_DEF = 3'b111;
   localparam logic [2:0] FLAG_LOG_DEF = 3'b110;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_AND   = 2'b01,
      OP_XOR   = 2'b10,
      OP_SHIFT = 2'b11
   } alu_oper_e;

   localparam logic [5:0] OPC_RTYPE = 6'd0;
   localparam logic [5:0] OPC_ADDI  = 6'd1;
   localparam logic [5:0] OPC_COMPI = 6'd2;

   localparam logic [4:0] FN_ADD  = 5'd0;
   localparam logic [4:0] FN_COMP = 5'd1;
   localparam logic [4:0] FN_AND  = 5'd2;
   localparam logic [4:0] FN_XOR  = 5'd3;
   localparam logic [4:0] FN_SHLL = 5'd4;
   localparam logic [4:0] FN_SHRL = 5'd5;
   localparam logic [4:0] FN_SHRA = 5'd6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ISSUE  = 2'd2
   } enc_state_e;

   function automatic logic [7:0] pack_alu_op(input logic       is_arith,
                                              input logic       is_twoc,
                                              input logic       left,
                                              input alu_oper_e  oper,
                                              input logic [2:0] flag);
      logic [7:0] b;
      b                   = 8'h00;
      b[BIT_ARITH]        = is_arith;
      b[BIT_TWOC]         = is_twoc;
      b[BIT_LR]           = left;
      b[OPER_HI:OPER_LO]  = oper;
      b[FLAG_HI:FLAG_LO]  = flag;
      return b;
   endfunction

endpackage

// File: rtl/alu_op_lut.sv
// Combinational opcode/funct to ALUop byte lookup with a legality flag.
module alu_op_lut
   import alu_op_pkg::*;
#(
   parameter int unsigned OPC_W    = OPC_W_DEF,
   parameter int unsigned FN_W     = FN_W_DEF,
   parameter logic [2:0]  FLAG_ALL = FLAG_ALL_DEF,
   parameter logic [2:0]  FLAG_LOG = FLAG_LOG_DEF
) (
   input  logic [OPC_W-1:0] opcode_i,
   input  logic [FN_W-1:0]  funct_i,
   output logic [7:0]       alu_op_o,
   output logic             legal_o
);

   // Decode table; anything not listed is illegal and yields a zero byte.
   always_comb begin
      alu_op_o = 8'h00;
      legal_o  = 1'b0;
      if (opcode_i == OPC_W'(OPC_RTYPE)) begin
         case (funct_i)
            FN_W'(FN_ADD):  begin alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b0, OP_ADD,   FLAG_ALL); legal_o = 1'b1; end
            FN_W'(FN_COMP): begin alu_op_o = pack_alu_op(1'b0, 1'b1, 1'b0, OP_ADD,   FLAG_ALL); legal_o = 1'b1; end
            FN_W'(FN_AND):  begin alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b0, OP_AND,   FLAG_LOG); legal_o = 1'b1; end
            FN_W'(FN_XOR):  begin alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b0, OP_XOR,   FLAG_LOG); legal_o = 1'b1; end
            FN_W'(FN_SHLL): begin alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b1, OP_SHIFT, FLAG_LOG); legal_o = 1'b1; end
            FN_W'(FN_SHRL): begin alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b0, OP_SHIFT, FLAG_LOG); legal_o = 1'b1; end
            FN_W'(FN_SHRA): begin alu_op_o = pack_alu_op(1'b1, 1'b0, 1'b0, OP_SHIFT, FLAG_LOG); legal_o = 1'b1; end
            default:        begin alu_op_o = 8'h00; legal_o = 1'b0; end
         endcase
      end else if (opcode_i == OPC_W'(OPC_ADDI)) begin
         alu_op_o = pack_alu_op(1'b0, 1'b0, 1'b0, OP_ADD, FLAG_ALL);
         legal_o  = 1'b1;
      end else if (opcode_i == OPC_W'(OPC_COMPI)) begin
         alu_op_o = pack_alu_op(1'b0, 1'b1, 1'b0, OP_ADD, FLAG_ALL);
         legal_o  = 1'b1;
      end else begin
         alu_op_o = 8'h00;
         legal_o  = 1'b0;
      end
   end

endmodule

// File: rtl/alu_op_encoder.sv
// IDLE/DECODE/ISSUE sequencer producing the registered ALUop byte with valid/ready
// handshakes. Optional saturating illegal counter under macro ALUOP_ILLEGAL_CNT_EN.
module alu_op_encoder
   import alu_op_pkg::*;
#(
   parameter int unsigned OPC_W    = OPC_W_DEF,
   parameter int unsigned FN_W     = FN_W_DEF,
   parameter logic [2:0]  FLAG_ALL = FLAG_ALL_DEF,
   parameter logic [2:0]  FLAG_LOG = FLAG_LOG_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OPC_W-1:0] opcode,
   input  logic [FN_W-1:0]  funct,
   output logic [7:0]       alu_op,
   output logic             alu_op_valid,
   input  logic             alu_ready,
   output logic             illegal
`ifdef ALUOP_ILLEGAL_CNT_EN
   ,output logic [7:0]      illegal_cnt
`endif
);

   enc_state_e       state_q, state_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   logic [FN_W-1:0]  fn_q, fn_d;
   logic [7:0]       alu_op_q, alu_op_d;
   logic             valid_q, valid_d;
   logic             illegal_q, illegal_d;
   logic             ready_q, ready_d;
   logic [7:0]       lut_byte_s;
   logic             lut_legal_s;

   alu_op_lut #(
      .OPC_W    (OPC_W),
      .FN_W     (FN_W),
      .FLAG_ALL (FLAG_ALL),
      .FLAG_LOG (FLAG_LOG)
   ) u_lut (
      .opcode_i (opc_q),
      .funct_i  (fn_q),
      .alu_op_o (lut_byte_s),
      .legal_o  (lut_legal_s)
   );

   // Next-state and output-register logic for the handshake sequencer.
   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      fn_d      = fn_q;
      alu_op_d  = alu_op_q;
      valid_d   = valid_q;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (instr_valid) begin
               opc_d   = opcode;
               fn_d    = funct;
               state_d = DECODE;
            end else begin
               state_d = IDLE;
            end
         end
         DECODE: begin
            if (lut_legal_s) begin
               alu_op_d = lut_byte_s;
               valid_d  = 1'b1;
               state_d  = ISSUE;
            end else begin
               alu_op_d  = 8'h00;
               valid_d   = 1'b0;
               illegal_d = 1'b1;
               state_d   = IDLE;
            end
         end
         ISSUE: begin
            // alu_op is left untouched so the last issued byte stays visible.
            if (alu_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         opc_q     <= '0;
         fn_q      <= '0;
         alu_op_q  <= 8'h00;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         opc_q     <= opc_d;
         fn_q      <= fn_d;
         alu_op_q  <= alu_op_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         ready_q   <= ready_d;
      end
   end

   assign instr_ready  = ready_q;
   assign alu_op       = alu_op_q;
   assign alu_op_valid = valid_q;
   assign illegal      = illegal_q;

`ifdef ALUOP_ILLEGAL_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   // Saturating count, stepped on the same edge that raises the illegal pulse.
   always_comb begin
      if (illegal_d && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Illegal counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign illegal_cnt = cnt_q;
`endif

endmodule

// File: doc/alu_op_encoder.md
Name: alu_op_encoder

Overview:
- Sequencing control stage that turns an accepted instruction's opcode/funct into the packed 8-bit ALUop byte consumed by the ALU control decoder.
- Layout of the byte is fixed: isArith[7], isTwoC[6], LeftOrRight[5], Operation[4:3], SetFlag[2:0].
- Sits between the instruction register and the ALU. Uses a valid/ready handshake on both sides so multi-cycle ALU ops can stall it.

Parameters:
- OPC_W, 6, opcode width
- FN_W, 5, funct width
- FLAG_ALL, 3'b111, SetFlag value for arithmetic ops (sign, zero, carry update)
- FLAG_LOG, 3'b110, SetFlag value for logic/shift ops (sign, zero only)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- instr_valid  in  1  opcode/funct valid
- instr_ready  out  1  encoder can accept instruction
- opcode  in  OPC_W  instruction opcode (0 = R-type, 1 = immediate)
- funct  in  FN_W  function code
- alu_op  out  8  packed ALUop byte, registered
- alu_op_valid  out  1  alu_op valid
- alu_ready  in  1  ALU accepts alu_op
- illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state=IDLE, instr_ready=1, alu_op=8'h00, alu_op_valid=0, illegal=0.
- FSM states: IDLE, DECODE, ISSUE.
  - IDLE: instr_ready=1. If instr_valid, latch opcode/funct and go to DECODE.
  - DECODE: instr_ready=0. Look up the byte and register it into alu_op.
    - Legal: go to ISSUE with alu_op_valid=1.
    - Illegal: illegal=1 for one cycle, alu_op=8'h00, return to IDLE.
  - ISSUE: alu_op_valid=1, alu_op held stable. When alu_ready=1, clear alu_op_valid and go to IDLE. alu_op keeps its last value.
- Latency: instruction accepted in cycle N → alu_op_valid=1 in cycle N+2. Minimum throughput is one instruction per 3 cycles.
- Encoding (opcode 0, by funct):
  - 0 add = 8'h07
  - 1 comp = 8'h47
  - 2 and = 8'h0E
  - 3 xor = 8'h16
  - 4 shll = 8'h3E
  - 5 shrl = 8'h1E
  - 6 shra = 8'h9E
  - funct 7..31 illegal
- Encoding (opcode 1, funct ignored): addi = 8'h07.
- Encoding (opcode 2, funct ignored): compi = 8'h47.
- Any other opcode is illegal.
- Boundary conditions:
  - instr_valid while not in IDLE: ignored, because instr_ready=0.
  - alu_ready held low: ISSUE holds indefinitely, no timeout.
  - alu_ready high outside ISSUE: ignored.
  - rst_n low in any state: next edge forces reset values. Any pending alu_op is discarded, with no partial handshake.
  - Back-to-back: instr_valid high in the IDLE cycle right after an ISSUE handshake is accepted in that cycle.

Optional Feature:
- Macro: ALUOP_ILLEGAL_CNT_EN.
- When defined: adds output illegal_cnt [7:0].
  - Increments on every illegal pulse and saturates at 8'hFF.
  - Reset to 0 by rst_n.
- When undefined: the port and the counter are absent, and illegal behaviour is otherwise identical.

Decomposition:
- Shared package alu_op_pkg holds:
  - ALUop field bit positions.
  - Operation codes: ADD=2'b00, AND=2'b01, XOR=2'b10, SHIFT=2'b11.
  - Opcode constants: R-type=0, ADDI=1, COMPI=2.
  - Funct constants for add through shra.
  - The FSM state enum.
- One combinational sub-module, alu_op_lut: inputs opcode and funct, outputs the 8-bit byte plus a legal flag. The FSM module instantiates it once.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with instr_valid=1 → alu_op=00, alu_op_valid=0, instr_ready=1, illegal=0.
- Full R-type sweep: opcode 0, funct 0..6, alu_ready=1 → alu_op = 07, 47, 0E, 16, 3E, 1E, 9E, each valid exactly 2 cycles after acceptance.
- Illegal inputs:
  - opcode 0, funct 9 → illegal pulses 1 cycle, alu_op_valid stays 0, back in IDLE next cycle.
  - opcode 5 → same response.
  - With ALUOP_ILLEGAL_CNT_EN, 300 illegal instructions → illegal_cnt=FF.
- Stall: opcode 1 (addi) with alu_ready=0 for 5 cycles → alu_op=07 held with alu_op_valid=1 and instr_ready=0 throughout; raising alu_ready completes the handshake.
- Reset mid-ISSUE: drive rst_n=0 while alu_op=3E and valid → next edge alu_op=00, alu_op_valid=0.
- Back-to-back: compi is accepted on the cycle after xor's handshake → alu_op sequence 16 then 47, with no dropped instruction.
